// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TMO_W    = 10;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } grant_t;

  // Command presented to memory for one access.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles and flags a hung memory access.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);

  logic [TMO_W-1:0] count;

  // Cleared when an access is granted, advances every BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active) begin
      count <= count + TMO_W'(1);
    end
  end

  // Expiry is combinational so the FSM can leave BUSY in the threshold cycle.
  if (TIMEOUT_CYCLES == 0) begin : gDisabled
    assign expired = 1'b0;
  end else begin : gEnabled
    assign expired = active && (count == TMO_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  arb_state_t          state;
  arb_state_t          nextState;
  grant_t              grantSel;
  grant_t              grantQ;
  logic                grantEn;
  logic                accessDone;
  logic                aborted;
  logic                expired;
  logic [STREAK_W-1:0] streak;
  mem_cmd_t            cmdSel;
  mem_cmd_t            memCmd;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and grant decision; data wins unless the streak limit is hit.
  always_comb begin
    nextState  = state;
    grantEn    = 1'b0;
    grantSel   = GNT_D;
    accessDone = 1'b0;
    aborted    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req || if_req) begin
          grantEn   = 1'b1;
          nextState = BUSY;
          if (!d_req || (if_req && (streak == STREAK_W'(DATA_STREAK_MAX)))) begin
            grantSel = GNT_IF;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          accessDone = 1'b1;
          nextState  = RESP;
        end else if (expired) begin
          accessDone = 1'b1;
          aborted    = 1'b1;
          nextState  = RESP;
        end
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Memory command for the port being granted; fetches are always plain reads.
  always_comb begin
    cmdSel = '0;
    if (grantSel == GNT_IF) begin
      cmdSel.addr = if_addr;
    end else begin
      cmdSel.we    = d_we;
      cmdSel.addr  = d_addr;
      cmdSel.wdata = d_we ? d_wdata : '0;
      cmdSel.be    = d_we ? d_be : '0;
    end
  end

  // Latch the command and granted port once per access; held through BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memCmd <= '0;
      grantQ <= GNT_IF;
    end else if (grantEn) begin
      memCmd <= cmdSel;
      grantQ <= grantSel;
    end
  end

  // Memory request: raised on grant, dropped when the access ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req <= 1'b0;
    end else if (grantEn) begin
      mem_req <= 1'b1;
    end else if (accessDone) begin
      mem_req <= 1'b0;
    end
  end

  // Capture read data on a real ack only; stores and aborts keep old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (accessDone && !aborted) begin
      if (grantQ == GNT_IF) begin
        if_rdata <= mem_rdata;
      end else if (!memCmd.we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  // One-cycle completion pulses, issued in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_ready <= accessDone && (grantQ == GNT_IF);
      d_ready  <= accessDone && (grantQ == GNT_D);
      err      <= aborted;
    end
  end

  // Consecutive data grants made while a fetch was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (grantEn) begin
      if ((grantSel == GNT_D) && if_req) begin
        if (streak != STREAK_W'(DATA_STREAK_MAX)) begin
          streak <= streak + STREAK_W'(1);
        end
      end else begin
        streak <= '0;
      end
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWatchdog (
    .clk    (clk),
    .reset  (reset),
    .start  (grantEn),
    .active (state == BUSY),
    .expired(expired)
  );

  assign mem_we    = memCmd.we;
  assign mem_addr  = memCmd.addr;
  assign mem_wdata = memCmd.wdata;
  assign mem_be    = memCmd.be;

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int STREAK_MAX = 4;
  localparam int TMO        = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_STREAK_MAX(STREAK_MAX),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .stall    (stall)
  );

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-addressed memory contents; untouched words hold an address hash.
  logic [31:0] memArr [int unsigned];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (memArr.exists(w)) return memArr[w];
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic void memWrite(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] word;
    word = memRead(a);
    for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = data[8*i +: 8];
    memArr[a >> 2] = word;
  endfunction

  // Memory responder: ack in the memLat-th BUSY cycle (0 = never).
  int memLat  = 1;
  int busyCnt = 0;
  bit spurAck = 1'b0;

  task automatic cycle();
    @(negedge clk);
    if (mem_req === 1'b1) begin
      busyCnt++;
      if (memLat != 0 && busyCnt == memLat) begin
        mem_ack = 1'b1;
        if (mem_we) memWrite(mem_addr, mem_wdata, mem_be);
        else mem_rdata = memRead(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      busyCnt   = 0;
      mem_ack   = spurAck && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  endtask

  // One isolated access; reports what the DUT did, counted from the request cycle.
  task automatic runOne(input bit isD, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int readyCyc, output int reqCyc, output bit errSeen,
                        output bit otherSeen, output bit fieldBad, output logic [31:0] rdataSeen);
    readyCyc = -1; reqCyc = 0; errSeen = 0; otherSeen = 0; fieldBad = 0; rdataSeen = '0;
    if (isD) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 1; n <= 40; n++) begin
      cycle();
      if (mem_req) begin
        reqCyc++;
        if (mem_addr !== addr || mem_we !== we || mem_be !== (we ? be : 4'b0000) ||
            (we && mem_wdata !== wdata)) fieldBad = 1'b1;
      end
      if (isD ? if_ready : d_ready) otherSeen = 1'b1;
      if (isD ? d_ready : if_ready) begin
        readyCyc  = n;
        errSeen   = err;
        rdataSeen = isD ? d_rdata : if_rdata;
        d_req = 1'b0; if_req = 1'b0;
        cycle();
        checkEq("readyPulseWidth", 32'({if_ready, d_ready, err}), 32'(0));
        break;
      end
    end
    if (readyCyc < 0) begin
      d_req = 1'b0; if_req = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rc, qc;
    bit es, os, fb;
    logic [31:0] rd;
    logic [31:0] expVal;
    int order[10];
    int nDone;

    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_ack = 0; mem_rdata = '0;

    // Reset state
    cycle(); cycle();
    checkEq("rstMemReq",  32'(mem_req), 32'(0));
    checkEq("rstReady",   32'({if_ready, d_ready, err}), 32'(0));
    checkEq("rstIfRdata", if_rdata, 32'(0));
    checkEq("rstDRdata",  d_rdata, 32'(0));
    checkEq("rstMemAddr", mem_addr, 32'(0));
    checkEq("rstMemBe",   32'(mem_be), 32'(0));
    checkEq("rstStall",   32'(stall), 32'(0));
    reset = 1'b0;
    cycle();

    // Single load, ack in the second BUSY cycle
    memArr[32'h100 >> 2] = 32'hDEAD_BEEF;
    memLat = 2;
    runOne(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rc, qc, es, os, fb, rd);
    checkEq("loadReadyCyc", 32'(rc), 32'(3));
    checkEq("loadReqCyc",   32'(qc), 32'(2));
    checkEq("loadRdata",    rd, 32'hDEAD_BEEF);
    checkEq("loadErr",      32'(es), 32'(0));
    checkEq("loadIfReady",  32'(os), 32'(0));
    checkEq("loadFields",   32'(fb), 32'(0));

    // Store: fields held until ack, d_rdata untouched
    memLat = 3;
    runOne(1'b1, 1'b1, 32'h204, 32'h1234_5678, 4'b0011, rc, qc, es, os, fb, rd);
    checkEq("storeReadyCyc", 32'(rc), 32'(4));
    checkEq("storeReqCyc",   32'(qc), 32'(3));
    checkEq("storeRdata",    rd, 32'hDEAD_BEEF);
    checkEq("storeFields",   32'(fb), 32'(0));
    checkEq("storeErr",      32'(es), 32'(0));

    // Timeout with no ack
    memLat = 0;
    runOne(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, rc, qc, es, os, fb, rd);
    checkEq("tmoReadyCyc", 32'(rc), 32'(TMO + 1));
    checkEq("tmoReqCyc",   32'(qc), 32'(TMO));
    checkEq("tmoErr",      32'(es), 32'(1));
    checkEq("tmoRdata",    rd, 32'hDEAD_BEEF);
    checkEq("tmoIdle",     32'(mem_req), 32'(0));

    // Ack exactly at the timeout threshold
    memArr[32'h400 >> 2] = 32'h55;
    memLat = TMO;
    runOne(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, rc, qc, es, os, fb, rd);
    checkEq("thrReadyCyc", 32'(rc), 32'(TMO + 1));
    checkEq("thrErr",      32'(es), 32'(0));
    checkEq("thrRdata",    rd, 32'h55);

    // Contention: both held, zero-wait memory; every fifth grant goes to fetch
    memLat = 1;
    if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    nDone = 0;
    for (int n = 0; n < 100 && nDone < 10; n++) begin
      cycle();
      if (if_ready || d_ready) begin
        order[nDone] = d_ready ? (if_ready ? 2 : 1) : 0;
        nDone++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checkEq("contGrants", 32'(nDone), 32'(10));
    for (int i = 0; i < 10; i++)
      checkEq($sformatf("grantOrder[%0d]", i), 32'(order[i]), 32'((i % 5 == 4) ? 0 : 1));
    cycle(); cycle();

    // Reset during BUSY: async drop of mem_req, no completion pulse
    memLat = 0;
    if_req = 1'b1; if_addr = 32'h40;
    cycle(); cycle(); cycle();
    checkEq("preRstMemReq", 32'(mem_req), 32'(1));
    reset = 1'b1;
    #1;
    checkEq("asyncMemReq", 32'(mem_req), 32'(0));
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkEq("rstNoPulse", 32'({if_ready, d_ready, err, mem_req}), 32'(0));
    end
    reset = 1'b0;
    cycle();
    checkEq("postRstNoPulse", 32'({if_ready, d_ready, err, mem_req}), 32'(0));
    memLat = 1;
    expVal = memRead(32'h0);
    runOne(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rc, qc, es, os, fb, rd);
    checkEq("postRstReadyCyc", 32'(rc), 32'(2));
    checkEq("postRstRdata",    rd, expVal);
    checkEq("postRstFields",   32'(fb), 32'(0));

    // Randomized traffic against a transaction-level model
    begin
      bit ifPend, dPend, curIsD, expErr, memReqPrev, gD;
      logic [31:0] ifA, dA, dWd, pendRd, expIfR, expDR;
      logic dWe;
      logic [3:0] dBe;
      int modelStreak, done, r;

      applyReset();
      spurAck = 1'b1;
      ifPend = 0; dPend = 0; curIsD = 0; expErr = 0; memReqPrev = 0;
      ifA = '0; dA = '0; dWd = '0; dWe = 0; dBe = '0; pendRd = '0;
      expIfR = '0; expDR = '0; modelStreak = 0; done = 0;
      memLat = 1;
      for (int cyc = 0; cyc < 20000 && done < 400; cyc++) begin
        cycle();
        if (mem_req && !memReqPrev) begin
          checkEq("grantWithoutReq", 32'({ifPend, dPend} == 2'b00), 32'(0));
          gD = dPend && !(ifPend && modelStreak == STREAK_MAX);
          curIsD = gD;
          if (gD) begin
            checkEq("dMemAddr", mem_addr, dA);
            checkEq("dMemWe",   32'(mem_we), 32'(dWe));
            checkEq("dMemBe",   32'(mem_be), 32'(dWe ? dBe : 4'b0000));
            if (dWe) checkEq("dMemWdata", mem_wdata, dWd);
            modelStreak = ifPend ? ((modelStreak < STREAK_MAX) ? modelStreak + 1 : modelStreak) : 0;
            pendRd = memRead(dA);
          end else begin
            checkEq("ifMemAddr", mem_addr, ifA);
            checkEq("ifMemWeBe", 32'({mem_we, mem_be}), 32'(0));
            modelStreak = 0;
            pendRd = memRead(ifA);
          end
          expErr = (memLat == 0) || (memLat > TMO);
        end
        memReqPrev = mem_req;
        checkEq("stall", 32'(stall), 32'((ifPend && !if_ready) || (dPend && !d_ready)));
        if (if_ready || d_ready) begin
          checkEq("readyPort", 32'({if_ready, d_ready}), 32'(curIsD ? 2'b01 : 2'b10));
          checkEq("err", 32'(err), 32'(expErr));
          if (curIsD) begin
            if (!dWe && !expErr) expDR = pendRd;
            checkEq("dRdata", d_rdata, expDR);
            dPend = 0; d_req = 1'b0;
          end else begin
            if (!expErr) expIfR = pendRd;
            checkEq("ifRdata", if_rdata, expIfR);
            ifPend = 0; if_req = 1'b0;
          end
          done++;
          r = $urandom_range(0, 19);
          memLat = (r == 0) ? 0 : (r == 1) ? TMO + 1 : (r == 2) ? TMO : $urandom_range(1, 4);
        end else begin
          checkEq("errIdle", 32'(err), 32'(0));
        end
        if (!ifPend && $urandom_range(0, 2) == 0) begin
          ifPend = 1;
          ifA = 32'($urandom_range(0, 63)) << 2;
          if_addr = ifA; if_req = 1'b1;
        end
        if (!dPend && $urandom_range(0, 1) == 0) begin
          dPend = 1;
          dA  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
          dWe = 1'($urandom_range(0, 1));
          dWd = $urandom;
          dBe = 4'($urandom_range(1, 15));
          d_addr = dA; d_we = dWe; d_wdata = dWd; d_be = dBe; d_req = 1'b1;
        end
      end
      checkEq("randomDone", 32'(done), 32'(400));
      spurAck = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port and its data (load/store) port. Requests are registered, forwarded to memory under a req/ack handshake, and answered with a registered one-cycle ready pulse. Data has priority; a streak counter prevents fetch starvation. A watchdog aborts hung memory transactions.

Parameters:
DATA_STREAK_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced (range 1..15)
TIMEOUT_CYCLES, 64, BUSY cycles without mem_ack before abort; 0 disables the watchdog (range 0..1023)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  32  fetch byte address
if_rdata  out  32  fetch data, valid with if_ready
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_rdata  out  32  load data, valid with d_ready
d_ready  out  1  one-cycle completion pulse for data
err  out  1  pulses with if_ready/d_ready when the transaction was aborted by timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables (4'b0000 for reads)
mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
mem_rdata  in  32  memory read data
stall  out  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready); to the hazard unit

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0, including if_rdata/d_rdata, streak counter and timeout counter.
- FSM states: IDLE, BUSY, RESP.
- IDLE: grant decision on the sampled requests.
  - d_req only -> grant data.
  - if_req only -> grant fetch.
  - both -> grant data, unless streak == DATA_STREAK_MAX; then grant fetch.
  - On grant: latch port fields into the mem_* registers (fetch: we=0, be=0); go to BUSY.
  - No request: stay IDLE with mem_req=0.
- BUSY: mem_req=1 and all mem_* fields stable.
  - On mem_ack: capture mem_rdata into the granted port's rdata register (reads only; stores leave d_rdata unchanged); go to RESP.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no ack, go to RESP with an abort flag; rdata is unchanged.
- RESP: pulse ready on the granted port for exactly one cycle; err=1 if aborted; mem_req=0; go to IDLE. Requests are ignored in RESP, so a held req is never double-granted.
- Requesters deassert req, or present a new request, in the cycle after ready.
- Latency: req seen in IDLE at cycle 0 -> mem_req from cycle 1 -> ack at cycle k (k>=1) -> ready at k+1 -> IDLE at k+2. Minimum 3 cycles per access.
- Streak counter (4-bit, saturating at DATA_STREAK_MAX):
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, and on a data grant with if_req=0.
- Timeout counter (10-bit): cleared on entry to BUSY, increments each BUSY cycle. A mem_ack in the same cycle as the timeout threshold wins, so the access completes normally.
- mem_ack outside BUSY is ignored.
- Reset mid-transaction: immediate return to IDLE; mem_req drops asynchronously; no ready pulse is issued.
- Inputs are not re-sampled during BUSY; requester changes to addr/wdata are ignored until the next grant.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY, RESP}
  - grant_t enum {GNT_IF, GNT_D}
  - Width constants: STREAK_W=4, TMO_W=10
- One sub-module, mem_arb_watchdog: the timeout counter, with inputs clk, reset, start, active and output expired. The top holds the FSM, streak counter and registers.

Test Plan:
- Single load: d_req=1, d_we=0, d_addr=0x100; mem_ack at cycle 2 with rdata 0xDEADBEEF -> mem_addr=0x100, mem_be=0; d_ready pulses at cycle 3 with d_rdata=0xDEADBEEF; if_ready stays 0.
- Store: d_we=1, d_addr=0x204, d_wdata=0x12345678, d_be=4'b0011 -> mem_we=1 and mem_be=0011 held until ack; d_rdata unchanged; d_ready pulses once.
- Contention and starvation: if_req and d_req held high continuously, zero-wait memory, DATA_STREAK_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; no if_ready while the streak is below 4.
- Timeout: TIMEOUT_CYCLES=8, mem_ack never asserted -> mem_req high for 8 cycles; then d_ready=1 and err=1 together for one cycle; state returns to IDLE.
- Ack at the timeout threshold: ack in the 8th BUSY cycle with rdata 0x55 -> normal completion, err=0, rdata=0x55.
- Reset mid-BUSY: assert reset while mem_req=1 -> mem_req=0 immediately, no ready/err pulse; after release, a new fetch to 0x0 completes normally.
